sevenseg_scan_driver: RTL

Time-multiplexed scan driver for the board's 8-digit common-anode seven-segment display. It captures a 32-bit hex value on a load strobe and cycles through the digits one at a time. For each digit it drives the active-low anode line and presents that digit's 4-bit nibble to the downstream `bcd_to_sevenseg_hex` decoder. It also drives the decimal point and inserts an anti-ghosting guard interval at each digit change.

---
 rtl/sevenseg_scan_driver.sv | 96 +++++++++
 1 files changed

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit common-anode seven-segment display.
// Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int NDIG        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic [3:0]  bcd,
    output logic [7:0]  an,
    output logic        dp,
    output logic [2:0]  digit_idx
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] P_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NDIG - 1);

    logic [PW-1:0] p;
    logic [2:0]    idx;
    logic [31:0]   sh_val;
    logic [7:0]    sh_dp;
    logic          in_guard;
    logic          visible;
    logic [7:0]    blank;
    logic [3:0]    bcd_n;
    logic [7:0]    an_n;
    logic          dp_n;

    generate
        if (GUARD == 0) begin : g_noguard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (p < PW'(GUARD));
        end
    endgenerate

`ifdef SEVENSEG_LZB_EN
    // A digit above 0 is blanked when it and every more-significant digit are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int i = 7; i >= 1; i--) begin
            if (i < NDIG) begin
                zero_run = zero_run & (sh_val[4*i +: 4] == 4'h0);
                blank[i] = zero_run;
            end
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        bcd_n   = sh_val[{idx, 2'b00} +: 4];
        visible = !in_guard && digit_en[idx] && !blank[idx];
        an_n    = 8'hFF;
        if (visible)
            an_n[idx] = 1'b0;
        dp_n    = ~(sh_dp[idx] & visible);
    end

    // Outputs register the terms computed from the current slot state, so they lag it by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            p         <= '0;
            idx       <= 3'd0;
            sh_val    <= 32'h0;
            sh_dp     <= 8'h0;
            bcd       <= 4'h0;
            an        <= 8'hFF;
            dp        <= 1'b1;
            digit_idx <= 3'd0;
        end else begin
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp_in;
            end
            if (p == P_LAST) begin
                p   <= '0;
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end else begin
                p <= p + PW'(1);
            end
            bcd       <= bcd_n;
            an        <= an_n;
            dp        <= dp_n;
            digit_idx <= idx;
        end
    end
endmodule
